// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory bus slave. It inserts programmable
//               wait states and gives sized, sign-extended loads and
//               byte-masked stores.
// Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0000_1000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic [63:0] HADDR,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] c_LIMIT    = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  c_WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_write;
    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [63:0] r_wdata;
    logic        w_accept, w_perform;

    logic [63:0] r_mem [DEPTH_WORDS];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_perform  = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_next = ST_IDLE;
                if (HSEL) begin
                    w_accept   = 1'b1;
                    w_cnt_next = c_WAIT_CNT;
                    if (c_WAIT_CNT == 4'd0) begin
                        w_next    = ST_RESP;
                        w_perform = 1'b1;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next    = ST_RESP;
                    w_perform = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens at the accept edge, so the
    // live bus inputs stand in for the not-yet-latched request.
    logic        w_wr;
    logic [63:0] w_addr, w_wdata;
    logic [2:0]  w_size;
    assign w_wr    = w_accept ? HWRITE : r_write;
    assign w_addr  = w_accept ? HADDR  : r_addr;
    assign w_size  = w_accept ? HSIZE  : r_size;
    assign w_wdata = w_accept ? HWDATA : r_wdata;

    logic [63:0]      w_offset, w_word, w_shifted, w_rdata, w_wshift, w_bitmask, w_merged;
    logic [2:0]       w_lane;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_bsize, w_bmask;
    logic             w_misalign, w_err, w_sext;

    always_comb begin
        w_offset = w_addr - BASE_ADDR;
        w_lane   = w_offset[2:0];
        w_idx    = w_offset[IDX_W+2:3];
        case (w_size[1:0])
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_addr[0];
            2'd2:    w_misalign = |w_addr[1:0];
            default: w_misalign = |w_addr[2:0];
        endcase
        w_err = (w_offset >= c_LIMIT) || w_misalign;

        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_lane, 3'b000};
        w_sext    = ~w_size[2];
        case (w_size[1:0])
            2'd0:    w_rdata = {{56{w_sext & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_rdata = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_rdata = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: w_rdata = w_shifted;
        endcase

        case (w_size[1:0])
            2'd0:    w_bsize = 8'h01;
            2'd1:    w_bsize = 8'h03;
            2'd2:    w_bsize = 8'h0F;
            default: w_bsize = 8'hFF;
        endcase
        w_bmask  = w_bsize << w_lane;
        w_wshift = w_wdata << {w_lane, 3'b000};
        for (int b = 0; b < 8; b++) begin
            w_bitmask[b*8 +: 8] = {8{w_bmask[b]}};
        end
        w_merged = (w_word & ~w_bitmask) | (w_wshift & w_bitmask);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 64'd0;
            r_size  <= 3'd0;
            r_wdata <= 64'd0;
            HREADY  <= 1'b0;
            HRESP   <= 1'b0;
            HRDATA  <= 64'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write <= HWRITE;
                r_addr  <= HADDR;
                r_size  <= HSIZE;
                r_wdata <= HWDATA;
            end
            HREADY <= w_perform;
            HRESP  <= w_perform && w_err;
            HRDATA <= (w_perform && !w_err && !w_wr) ? w_rdata : 64'd0;
        end
    end

    // Storage is deliberately not reset; RESET gating drops any store while reset is held.
    always_ff @(posedge CLK) begin
        if (RESET && w_perform && w_wr && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        hsel2 = 1'b0, hsel0 = 1'b0;
    logic        hwrite = 1'b0;
    logic [63:0] haddr = 64'd0, hwdata = 64'd0;
    logic [2:0]  hsize = 3'd0;
    logic [63:0] hrdata2, hrdata0;
    logic        hready2, hready0, hresp2, hresp0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    mem_responder #(.BASE_ADDR(64'h1000), .DEPTH_WORDS(512), .WAIT_STATES(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .HSEL(hsel2), .HWRITE(hwrite), .HADDR(haddr),
        .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2)
    );

    mem_responder #(.BASE_ADDR(64'h1000), .DEPTH_WORDS(512), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .HSEL(hsel0), .HWRITE(hwrite), .HADDR(haddr),
        .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [63:0] addr, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output logic rsp,
                        output int lat);
        @(negedge CLK);
        hsel2 = 1'b1; hwrite = wr; haddr = addr; hsize = sz; hwdata = wd;
        @(posedge CLK);
        #1 hsel2 = 1'b0;
        lat = 0; rd = 64'd0; rsp = 1'b0;
        while (lat < 20) begin
            @(negedge CLK);
            lat++;
            if (hready2) begin
                rd  = hrdata2;
                rsp = hresp2;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic wr, input logic [63:0] addr,
                         input logic [2:0] sz, input logic [63:0] wd,
                         input logic [63:0] exp_d, input logic exp_r);
        logic [63:0] d;
        logic        r;
        int          lat;
        xfer(wr, addr, sz, wd, d, r, lat);
        chk({tag, "_lat"},  64'(lat), 64'd3);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_resp"}, {63'd0, r}, {63'd0, exp_r});
    endtask

    logic        bw [4];
    logic [63:0] ba [4];
    logic [63:0] bd [4];
    logic [63:0] be [4];
    logic        seen;

    initial begin
        #1;
        chk("rst_ready",  {63'd0, hready2}, 64'd0);
        chk("rst_resp",   {63'd0, hresp2},  64'd0);
        chk("rst_rdata",  hrdata2,          64'd0);
        chk("rst_ready0", {63'd0, hready0}, 64'd0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b1;

        // dword write/read with 2 wait states
        do_op("wr_dw",  1'b1, 64'h1008, 3'd3, 64'h1122334455667788, 64'd0, 1'b0);
        @(negedge CLK);
        chk("pulse_one", {63'd0, hready2}, 64'd0);
        do_op("rd_dw",  1'b0, 64'h1008, 3'd3, 64'd0, 64'h1122334455667788, 1'b0);
        do_op("rd_dw7", 1'b0, 64'h1008, 3'd7, 64'd0, 64'h1122334455667788, 1'b0);

        // sign/zero extension
        do_op("wr_w0",  1'b1, 64'h1000, 3'd3, 64'h80FF_0000_0000_0000, 64'd0, 1'b0);
        do_op("rd_b7s", 1'b0, 64'h1007, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        do_op("rd_b7u", 1'b0, 64'h1007, 3'd4, 64'd0, 64'h80, 1'b0);
        do_op("rd_h6s", 1'b0, 64'h1006, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0);
        do_op("rd_w4s", 1'b0, 64'h1004, 3'd2, 64'd0, 64'hFFFF_FFFF_80FF_0000, 1'b0);

        // partial byte write
        do_op("clr_w0", 1'b1, 64'h1000, 3'd3, 64'd0, 64'd0, 1'b0);
        do_op("wr_b3",  1'b1, 64'h1003, 3'd0, 64'h0000_0000_0000_55AB, 64'd0, 1'b0);
        do_op("rd_pw",  1'b0, 64'h1000, 3'd3, 64'd0, 64'h0000_0000_AB00_0000, 1'b0);

        // errors and range boundaries
        do_op("err_mis",  1'b0, 64'h1002, 3'd2, 64'd0, 64'd0, 1'b1);
        do_op("err_top",  1'b0, 64'h2000, 3'd0, 64'd0, 64'd0, 1'b1);
        do_op("err_low",  1'b0, 64'h0FF8, 3'd3, 64'd0, 64'd0, 1'b1);
        do_op("err_wr",   1'b1, 64'h1004, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        do_op("rd_nochg", 1'b0, 64'h1000, 3'd3, 64'd0, 64'h0000_0000_AB00_0000, 1'b0);
        do_op("wr_last",  1'b1, 64'h1FF8, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0);
        do_op("rd_last",  1'b0, 64'h1FF8, 3'd3, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        // back-to-back on the zero-wait-state instance, including read-after-write
        bw[0] = 1'b1; ba[0] = 64'h1000; bd[0] = 64'h111; be[0] = 64'd0;
        bw[1] = 1'b1; ba[1] = 64'h1008; bd[1] = 64'h222; be[1] = 64'd0;
        bw[2] = 1'b0; ba[2] = 64'h1000; bd[2] = 64'd0;   be[2] = 64'h111;
        bw[3] = 1'b0; ba[3] = 64'h1008; bd[3] = 64'd0;   be[3] = 64'h222;
        @(negedge CLK);
        hsel0 = 1'b1; hwrite = bw[0]; haddr = ba[0]; hsize = 3'd3; hwdata = bd[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            if (k < 3) begin
                hwrite = bw[k+1]; haddr = ba[k+1]; hwdata = bd[k+1];
            end else begin
                hsel0 = 1'b0;
            end
            @(negedge CLK);
            chk($sformatf("b2b_ready%0d", k), {63'd0, hready0}, 64'd1);
            chk($sformatf("b2b_data%0d", k),  hrdata0, be[k]);
        end
        @(negedge CLK);
        chk("b2b_end", {63'd0, hready0}, 64'd0);

        // reset during the completion cycle clears outputs asynchronously
        do_op("wr_tgt", 1'b1, 64'h1010, 3'd3, 64'h5555, 64'd0, 1'b0);
        @(negedge CLK);
        hsel2 = 1'b1; hwrite = 1'b0; haddr = 64'h1010; hsize = 3'd3;
        @(posedge CLK);
        #1 hsel2 = 1'b0;
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
        chk("resp_pre_rst", {63'd0, hready2}, 64'd1);
        RESET = 1'b0;
        #1;
        chk("rst_async_ready", {63'd0, hready2}, 64'd0);
        chk("rst_async_data",  hrdata2, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // reset during WAIT of a write drops the store
        @(negedge CLK);
        hsel2 = 1'b1; hwrite = 1'b1; haddr = 64'h1010; hsize = 3'd3; hwdata = 64'hBAD;
        @(posedge CLK);
        #1 hsel2 = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rstw_ready", {63'd0, hready2}, 64'd0);
        chk("rstw_resp",  {63'd0, hresp2},  64'd0);
        chk("rstw_data",  hrdata2, 64'd0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (hready2) seen = 1'b1;
        end
        chk("no_ready_after_rst", {63'd0, seen}, 64'd0);
        do_op("rd_tgt", 1'b0, 64'h1010, 3'd3, 64'd0, 64'h5555, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-mapped bus responder: the slave end of the request bus that `mem_controller` drives for instruction fetch and load/store. It accepts a single outstanding read or write, inserts a programmable number of wait states, and then completes the transfer with a one-cycle `HREADY` pulse. Reads return sign- or zero-extended data and writes update only the addressed bytes. It replaces the zero-latency `iram`, so stall handling can be exercised against realistic memory latency.

## Interface
- `BASE_ADDR`, default 64'h0000_0000_0000_1000: first byte address decoded by this block.
- `DEPTH_WORDS`, default 512: number of 64-bit storage words. Must be a power of two.
- `WAIT_STATES`, default 2: extra cycles between accept and completion. Legal range 0–15.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `HSEL`  in  1  request valid.
- `HWRITE`  in  1  1 = write, 0 = read.
- `HADDR`  in  64  byte address.
- `HSIZE`  in  3  access size, funct3 encoding. [1:0]: 0 = byte, 1 = half, 2 = word, 3 = dword. [2] = unsigned load.
- `HWDATA`  in  64  store data, right-aligned.
- `HRDATA`  out  64  load data, valid only while `HREADY`=1.
- `HREADY`  out  1  one-cycle completion pulse.
- `HRESP`  out  1  error flag, qualified by `HREADY`.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **Accept.** In IDLE or RESP, `HSEL`=1 accepts a request at the clock edge. `HWRITE`, `HADDR`, `HSIZE` and `HWDATA` are latched at that edge. After acceptance the inputs are ignored until the next accept point.
- **Countdown.** On accept, the wait counter loads `WAIT_STATES`. The FSM goes to WAIT if `WAIT_STATES`>0, otherwise directly to RESP.
  - In WAIT the counter decrements each cycle.
  - When the counter reaches 1, the FSM goes to RESP on the next edge.
- **Completion.** In RESP, `HREADY`=1 for exactly one cycle. The access is performed at the edge that enters RESP.
  - Next state is WAIT or RESP if `HSEL`=1 (back-to-back accept), otherwise IDLE.
- **Error detection.** The error is computed from the latched request.
  - Out-of-range: offset = `HADDR`−`BASE_ADDR` is not less than `DEPTH_WORDS`*8.
  - Misaligned: `HADDR` is not a multiple of 2^`HSIZE[1:0]`.
  - On error: `HRESP`=1, `HRDATA`=0, and memory is unchanged.
- **Index.** Word index = offset[3+log2(`DEPTH_WORDS`)-1:3]. Byte lane = offset[2:0].
- **Read.** Select the `HSIZE`-wide field at the byte lane and shift it right to bit 0. Zero-extend if `HSIZE[2]`=1, otherwise sign-extend from the field MSB. Dword reads ignore `HSIZE[2]`.
- **Write.** Read-modify-write of the addressed word. Only the 1, 2, 4 or 8 bytes selected by size and lane change. `HRDATA`=0 on writes.
- **Illegal encoding.** `HSIZE`=3'b111 is treated as a dword access.
- **Memory contents.** Storage is not reset. It may be preloaded through `$readmemh` in simulation only.

## Timing
- **Reset values** (while `RESET`=0, asynchronous):
  - state = IDLE, counter = 0.
  - `HREADY`=0, `HRESP`=0, `HRDATA`=0.
  - Latched request registers = 0.
- **Latency.** Accept at edge N gives `HREADY`=1 during cycle N+`WAIT_STATES`+1.
  - `WAIT_STATES`=0 means one-cycle latency.
- **Throughput.** With `HSEL` held high, one transfer completes every `WAIT_STATES`+1 cycles.
- **Outputs.** All outputs are registered. There is no combinational path from any input to any output.
- **Read-after-write.** A read accepted in the RESP cycle of a write to the same word returns the newly written data.
- **Reset mid-transfer.** Reset asserted in WAIT or RESP aborts the transfer.
  - A write not yet performed is dropped.
  - A write already performed (on entry to RESP) is kept.
  - No `HREADY` is issued after reset deasserts until a new request is accepted.
- **Outside IDLE/RESP.** `HSEL` is don't-care in the WAIT state.

## Test plan
- **Basic read/write, dword.** `WAIT_STATES`=2. Write dword 64'h1122334455667788 at `BASE_ADDR`+8, then read it back. Required: each `HREADY` appears 3 cycles after its accept, and the read returns the same value with `HRESP`=0.
- **Byte and half extension.** Preload word 0 = 64'h80FF_0000_0000_0000. Read byte at +7 (`HSIZE`=0), byte at +7 with `HSIZE`=4, and half at +6. Required results, in order: 64'hFFFF_FFFF_FFFF_FF80, then 64'h80, then 64'hFFFF_FFFF_FFFF_80FF.
- **Partial write.** Store byte 8'hAB at +3 into word 0 = 0. Required: a subsequent dword read returns 64'h0000_0000_AB00_0000.
- **Errors.** Word read at `BASE_ADDR`+2, and any read at `BASE_ADDR`+`DEPTH_WORDS`*8. Required for each: `HREADY`=1 with `HRESP`=1 and `HRDATA`=0. A misaligned write leaves memory unchanged.
- **Back-to-back.** `HSEL` held high for 4 requests with `WAIT_STATES`=0. Required: `HREADY` high for 4 consecutive cycles and correct data in order.
- **Reset mid-transfer.** Pull `RESET` low during WAIT of a write. Required: all outputs immediately 0, the target word unchanged, and no `HREADY` after reset is released.
